l1_vc_miss_controller: RTL and testbench

- Direct-mapped L1 data-cache controller: the initiator side of the victim-cache (VC) protocol.
- On an L1 miss it probes the VC first. On a VC hit it fills the L1 from the VC; on a VC miss it fills from memory.
- In both cases the displaced L1 line is pushed into the VC as a one-cycle evict record.
- Sits between the CPU load/store port, the external L1 tag/data arrays, the victim cache and the memory controller.

---
 rtl/cache_def.sv | 36 +++
 rtl/l1vc_perf_counters.sv | 46 ++++
 rtl/l1_vc_miss_controller.sv | 212 +++++++++++++++++++++
 tb/tb_l1_vc_miss_controller.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_def.sv
// Shared definitions for the L1 / victim-cache datapath.
// Holds the default geometry constants, the L1 tag word and evict record
// layouts, and the miss-controller state encoding.
package cache_def;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned INDEX_W  = 8;
  localparam int unsigned OFFSET_W = 4;
  localparam int unsigned LINE_W   = 8 << OFFSET_W;
  localparam int unsigned TAG_W    = ADDR_W - INDEX_W - OFFSET_W;

  // Tag array word: {valid, dirty, tag}
  typedef struct packed {
    logic             valid;
    logic             dirty;
    logic [TAG_W-1:0] tag;
  } l1_tag_type;

  // Record pushed into the victim cache when an L1 line is displaced
  typedef struct packed {
    logic              valid;
    logic              dirty;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] data;
  } evict_data_type;

  typedef enum logic [2:0] {
    StIdle,
    StCompare,
    StVcReq,
    StVcWait,
    StMemReq,
    StFill
  } l1vc_state_type;

endpackage

// File: rtl/l1vc_perf_counters.sv
// Performance counters for the L1 victim-cache miss controller.
// Built only when L1VC_PERF_CNT_EN is defined.
//   state_i     : controller state
//   tag_hit_i   : L1 tag compare result for the current request
//   vc_hit_i    : victim-cache hit response
//   no_acc_o    : accesses (COMPARE entered from IDLE)
//   no_hit_o    : hits on the first compare of an access
//   no_vc_hit_o : victim-cache hits
//   no_miss_o   : memory fills (MEM_REQ entries)
module l1vc_perf_counters
  import cache_def::*;
(
  input  logic           clk_i,
  input  logic           rst_ni,
  input  l1vc_state_type state_i,
  input  logic           tag_hit_i,
  input  logic           vc_hit_i,
  output logic [31:0]    no_acc_o,
  output logic [31:0]    no_hit_o,
  output logic [31:0]    no_vc_hit_o,
  output logic [31:0]    no_miss_o
);

  l1vc_state_type prev_q;
  logic           first_cmp;

  // A compare reached from FILL is the re-compare of the same access
  assign first_cmp = (state_i == StCompare) && (prev_q == StIdle);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q      <= StIdle;
      no_acc_o    <= '0;
      no_hit_o    <= '0;
      no_vc_hit_o <= '0;
      no_miss_o   <= '0;
    end else begin
      prev_q <= state_i;
      if (first_cmp) no_acc_o <= no_acc_o + 32'd1;
      if (first_cmp && tag_hit_i) no_hit_o <= no_hit_o + 32'd1;
      if ((state_i == StVcWait) && vc_hit_i) no_vc_hit_o <= no_vc_hit_o + 32'd1;
      if ((state_i == StMemReq) && (prev_q == StVcWait)) no_miss_o <= no_miss_o + 32'd1;
    end
  end

endmodule

// File: rtl/l1_vc_miss_controller.sv
// Direct-mapped L1 data-cache controller, initiator side of the victim-cache
// protocol. A miss probes the VC, fills from the VC or memory, and pushes the
// displaced line into the VC as a one-cycle evict record.
// Optional macro L1VC_PERF_CNT_EN adds the four performance counters; without
// it the counter outputs are tied to zero.
// Ports:
//   cpu_req_*/cpu_res_* : CPU load/store port (request held until ready pulse)
//   l1_*                : external tag/data arrays (combinational read)
//   vc_lookup_*, vc_*   : victim-cache probe and response
//   evict_*             : evict record to the victim cache
//   mem_*               : memory line read
//   no_*_o              : performance counters
module l1_vc_miss_controller
  import cache_def::*;
#(
  parameter int unsigned ADDR_W   = cache_def::ADDR_W,
  parameter int unsigned INDEX_W  = cache_def::INDEX_W,
  parameter int unsigned OFFSET_W = cache_def::OFFSET_W,
  parameter int unsigned LINE_W   = 8 << OFFSET_W,
  parameter int unsigned TAG_W    = ADDR_W - INDEX_W - OFFSET_W
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                cpu_req_valid_i,
  input  logic                cpu_req_rw_i,
  input  logic [ADDR_W-1:0]   cpu_req_addr_i,
  input  logic [31:0]         cpu_req_data_i,
  output logic                cpu_res_ready_o,
  output logic [31:0]         cpu_res_data_o,
  output logic [INDEX_W-1:0]  l1_index_o,
  input  logic [TAG_W+1:0]    l1_tag_read_i,
  input  logic [LINE_W-1:0]   l1_data_read_i,
  output logic                l1_we_o,
  output logic [TAG_W+1:0]    l1_tag_write_o,
  output logic [LINE_W-1:0]   l1_data_write_o,
  output logic                vc_lookup_valid_o,
  output logic [ADDR_W-1:0]   vc_lookup_addr_o,
  input  logic                vc_hit_i,
  input  logic                vc_dirty_i,
  input  logic [LINE_W-1:0]   vc_data_i,
  output logic                evict_valid_o,
  output logic [ADDR_W-1:0]   evict_addr_o,
  output logic                evict_dirty_o,
  output logic [LINE_W-1:0]   evict_data_o,
  output logic                mem_req_valid_o,
  output logic [ADDR_W-1:0]   mem_req_addr_o,
  input  logic                mem_ready_i,
  input  logic [LINE_W-1:0]   mem_rdata_i,
  output logic [31:0]         no_acc_o,
  output logic [31:0]         no_hit_o,
  output logic [31:0]         no_vc_hit_o,
  output logic [31:0]         no_miss_o
);

  localparam int unsigned Words = LINE_W / 32;
  localparam int unsigned SelW  = OFFSET_W - 2;

  l1vc_state_type   state_q;
  evict_data_type   old_q;
  l1_tag_type       tag_rd;
  logic [TAG_W-1:0] req_tag;
  logic [INDEX_W-1:0] req_index;
  logic [SelW-1:0]  word_sel;
  logic [ADDR_W-1:0] line_addr;
  logic             tag_hit;
  logic [31:0]      rd_word;
  logic [LINE_W-1:0] merged_line;
  logic             fill_go;
  logic             fill_dirty;
  logic [LINE_W-1:0] fill_data;
  logic             unused_addr_lsbs;

  assign req_tag          = cpu_req_addr_i[ADDR_W-1 -: TAG_W];
  assign req_index        = cpu_req_addr_i[OFFSET_W +: INDEX_W];
  assign word_sel         = cpu_req_addr_i[OFFSET_W-1:2];
  assign line_addr        = {cpu_req_addr_i[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
  assign l1_index_o       = req_index;
  assign tag_rd           = l1_tag_read_i;
  assign tag_hit          = tag_rd.valid && (tag_rd.tag == req_tag);
  assign unused_addr_lsbs = ^cpu_req_addr_i[1:0];

  always_comb begin
    rd_word     = '0;
    merged_line = l1_data_read_i;
    for (int unsigned w = 0; w < Words; w++) begin
      if (word_sel == SelW'(w)) begin
        rd_word                 = l1_data_read_i[w*32 +: 32];
        merged_line[w*32 +: 32] = cpu_req_data_i;
      end
    end
  end

  // Both fill sources converge here; memory lines always arrive clean
  assign fill_go    = ((state_q == StVcWait) && vc_hit_i) ||
                      ((state_q == StMemReq) && mem_ready_i);
  assign fill_dirty = (state_q == StVcWait) && vc_dirty_i;
  assign fill_data  = (state_q == StVcWait) ? vc_data_i : mem_rdata_i;

  // Outputs are registered for the state being entered, so each pulse lines
  // up with the cycle the controller spends in the corresponding state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q           <= StIdle;
      old_q             <= '0;
      cpu_res_ready_o   <= 1'b0;
      cpu_res_data_o    <= '0;
      l1_we_o           <= 1'b0;
      l1_tag_write_o    <= '0;
      l1_data_write_o   <= '0;
      vc_lookup_valid_o <= 1'b0;
      vc_lookup_addr_o  <= '0;
      evict_valid_o     <= 1'b0;
      evict_addr_o      <= '0;
      evict_dirty_o     <= 1'b0;
      evict_data_o      <= '0;
      mem_req_valid_o   <= 1'b0;
      mem_req_addr_o    <= '0;
    end else begin
      cpu_res_ready_o   <= 1'b0;
      cpu_res_data_o    <= '0;
      l1_we_o           <= 1'b0;
      l1_tag_write_o    <= '0;
      l1_data_write_o   <= '0;
      vc_lookup_valid_o <= 1'b0;
      vc_lookup_addr_o  <= '0;
      evict_valid_o     <= 1'b0;
      evict_addr_o      <= '0;
      evict_dirty_o     <= 1'b0;
      evict_data_o      <= '0;
      mem_req_valid_o   <= 1'b0;
      mem_req_addr_o    <= '0;
      unique case (state_q)
        StIdle: begin
          // The request is still held during the ready cycle; don't relaunch it
          if (cpu_req_valid_i && !cpu_res_ready_o) state_q <= StCompare;
        end
        StCompare: begin
          if (tag_hit) begin
            cpu_res_ready_o <= 1'b1;
            if (cpu_req_rw_i) begin
              l1_we_o         <= 1'b1;
              l1_tag_write_o  <= {1'b1, 1'b1, req_tag};
              l1_data_write_o <= merged_line;
            end else begin
              cpu_res_data_o <= rd_word;
            end
            state_q <= StIdle;
          end else begin
            old_q.valid       <= tag_rd.valid;
            old_q.dirty       <= tag_rd.dirty;
            old_q.addr        <= {tag_rd.tag, req_index, {OFFSET_W{1'b0}}};
            old_q.data        <= l1_data_read_i;
            vc_lookup_valid_o <= 1'b1;
            vc_lookup_addr_o  <= line_addr;
            state_q           <= StVcReq;
          end
        end
        StVcReq: state_q <= StVcWait;
        StVcWait: begin
          if (vc_hit_i) begin
            state_q <= StFill;
          end else begin
            mem_req_valid_o <= 1'b1;
            mem_req_addr_o  <= line_addr;
            state_q         <= StMemReq;
          end
        end
        StMemReq: begin
          if (mem_ready_i) begin
            state_q <= StFill;
          end else begin
            mem_req_valid_o <= 1'b1;
            mem_req_addr_o  <= line_addr;
          end
        end
        StFill: state_q <= StCompare;
        default: state_q <= StIdle;
      endcase
      if (fill_go) begin
        l1_we_o         <= 1'b1;
        l1_tag_write_o  <= {1'b1, fill_dirty, req_tag};
        l1_data_write_o <= fill_data;
        if (old_q.valid) begin
          evict_valid_o <= 1'b1;
          evict_addr_o  <= old_q.addr;
          evict_dirty_o <= old_q.dirty;
          evict_data_o  <= old_q.data;
        end
      end
    end
  end

`ifdef L1VC_PERF_CNT_EN
  l1vc_perf_counters u_perf_counters (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .state_i     (state_q),
    .tag_hit_i   (tag_hit),
    .vc_hit_i    (vc_hit_i),
    .no_acc_o    (no_acc_o),
    .no_hit_o    (no_hit_o),
    .no_vc_hit_o (no_vc_hit_o),
    .no_miss_o   (no_miss_o)
  );
`else
  assign no_acc_o    = '0;
  assign no_hit_o    = '0;
  assign no_vc_hit_o = '0;
  assign no_miss_o   = '0;
`endif

endmodule

// File: tb/tb_l1_vc_miss_controller.sv
// Self-checking bench for l1_vc_miss_controller: an L1 array model, a VC
// responder and a memory responder around the DUT, with a line-level cache
// reference model predicting responses, latencies, evicts and array contents.
module tb_l1_vc_miss_controller;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         cpu_req_valid_i = 1'b0;
  logic         cpu_req_rw_i = 1'b0;
  logic [31:0]  cpu_req_addr_i = '0;
  logic [31:0]  cpu_req_data_i = '0;
  logic         cpu_res_ready_o;
  logic [31:0]  cpu_res_data_o;
  logic [7:0]   l1_index_o;
  logic [21:0]  l1_tag_read_i;
  logic [127:0] l1_data_read_i;
  logic         l1_we_o;
  logic [21:0]  l1_tag_write_o;
  logic [127:0] l1_data_write_o;
  logic         vc_lookup_valid_o;
  logic [31:0]  vc_lookup_addr_o;
  logic         vc_hit_i = 1'b0;
  logic         vc_dirty_i = 1'b0;
  logic [127:0] vc_data_i = '0;
  logic         evict_valid_o;
  logic [31:0]  evict_addr_o;
  logic         evict_dirty_o;
  logic [127:0] evict_data_o;
  logic         mem_req_valid_o;
  logic [31:0]  mem_req_addr_o;
  logic         mem_ready_i = 1'b0;
  logic [127:0] mem_rdata_i;
  logic [31:0]  no_acc_o, no_hit_o, no_vc_hit_o, no_miss_o;

  int errors = 0;
  int checks = 0;

  l1_vc_miss_controller dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .cpu_req_valid_i   (cpu_req_valid_i),
    .cpu_req_rw_i      (cpu_req_rw_i),
    .cpu_req_addr_i    (cpu_req_addr_i),
    .cpu_req_data_i    (cpu_req_data_i),
    .cpu_res_ready_o   (cpu_res_ready_o),
    .cpu_res_data_o    (cpu_res_data_o),
    .l1_index_o        (l1_index_o),
    .l1_tag_read_i     (l1_tag_read_i),
    .l1_data_read_i    (l1_data_read_i),
    .l1_we_o           (l1_we_o),
    .l1_tag_write_o    (l1_tag_write_o),
    .l1_data_write_o   (l1_data_write_o),
    .vc_lookup_valid_o (vc_lookup_valid_o),
    .vc_lookup_addr_o  (vc_lookup_addr_o),
    .vc_hit_i          (vc_hit_i),
    .vc_dirty_i        (vc_dirty_i),
    .vc_data_i         (vc_data_i),
    .evict_valid_o     (evict_valid_o),
    .evict_addr_o      (evict_addr_o),
    .evict_dirty_o     (evict_dirty_o),
    .evict_data_o      (evict_data_o),
    .mem_req_valid_o   (mem_req_valid_o),
    .mem_req_addr_o    (mem_req_addr_o),
    .mem_ready_i       (mem_ready_i),
    .mem_rdata_i       (mem_rdata_i),
    .no_acc_o          (no_acc_o),
    .no_hit_o          (no_hit_o),
    .no_vc_hit_o       (no_vc_hit_o),
    .no_miss_o         (no_miss_o)
  );

  always #5 clk_i = ~clk_i;

  // Memory contents: a fixed function of the line address
  function automatic logic [127:0] mem_line(input logic [31:0] a);
    logic [127:0] l;
    for (int i = 0; i < 4; i++) begin
      l[i*32 +: 32] = (a * 32'h9E3779B1) ^ (32'h01010101 * i) ^ 32'h5A5A0000;
    end
    return l;
  endfunction

  assign mem_rdata_i = mem_line(mem_req_addr_o);

  // External L1 arrays
  logic [21:0]  tag_mem [256];
  logic [127:0] data_mem [256];
  logic         env_init = 1'b1;

  assign l1_tag_read_i  = tag_mem[l1_index_o];
  assign l1_data_read_i = data_mem[l1_index_o];

  always @(posedge clk_i) begin
    if (env_init) begin
      for (int i = 0; i < 256; i++) begin
        tag_mem[i]  <= '0;
        data_mem[i] <= '0;
      end
    end else if (l1_we_o) begin
      tag_mem[l1_index_o]  <= l1_tag_write_o;
      data_mem[l1_index_o] <= l1_data_write_o;
    end
  end

  // Output monitor and memory responder
  int           n_probe = 0, n_evict = 0, n_mem = 0, n_we = 0, n_both = 0;
  logic [31:0]  last_probe_addr = '0, last_ev_addr = '0, last_mem_addr = '0;
  logic         last_ev_dirty = 1'b0;
  logic [127:0] last_ev_data = '0;
  int           mem_delay = 0;
  int           mem_wait = 0;

  always @(negedge clk_i) begin
    if (vc_lookup_valid_o) begin
      n_probe++;
      last_probe_addr = vc_lookup_addr_o;
    end
    if (evict_valid_o) begin
      n_evict++;
      last_ev_addr  = evict_addr_o;
      last_ev_dirty = evict_dirty_o;
      last_ev_data  = evict_data_o;
    end
    if (evict_valid_o && vc_lookup_valid_o) n_both++;
    if (l1_we_o) n_we++;
    if (mem_req_valid_o) begin
      n_mem++;
      last_mem_addr = mem_req_addr_o;
      if (mem_wait >= mem_delay) begin
        mem_ready_i = 1'b1;
      end else begin
        mem_ready_i = 1'b0;
        mem_wait++;
      end
    end else begin
      mem_ready_i = 1'b0;
      mem_wait    = 0;
    end
  end

  // Reference model: line-level cache state
  bit           ref_valid [256];
  logic         ref_dirty [256];
  logic [19:0]  ref_tag [256];
  logic [127:0] ref_data [256];
  int           m_acc = 0, m_hit = 0, m_vc = 0, m_miss = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs_zero();
    chk("rst_ready", 128'(cpu_res_ready_o), '0);
    chk("rst_rdata", 128'(cpu_res_data_o), '0);
    chk("rst_we", 128'({l1_we_o, l1_tag_write_o}), '0);
    chk("rst_wdata", l1_data_write_o, '0);
    chk("rst_probe", 128'({vc_lookup_valid_o, vc_lookup_addr_o}), '0);
    chk("rst_evict", 128'({evict_valid_o, evict_dirty_o, evict_addr_o}), '0);
    chk("rst_evdata", evict_data_o, '0);
    chk("rst_mem", 128'({mem_req_valid_o, mem_req_addr_o}), '0);
    chk("rst_cnt", 128'({no_acc_o, no_hit_o, no_vc_hit_o, no_miss_o}), '0);
  endtask

  task automatic chk_counters();
`ifdef L1VC_PERF_CNT_EN
    chk("cnt_acc", 128'(no_acc_o), 128'(m_acc));
    chk("cnt_hit", 128'(no_hit_o), 128'(m_hit));
    chk("cnt_vc_hit", 128'(no_vc_hit_o), 128'(m_vc));
    chk("cnt_miss", 128'(no_miss_o), 128'(m_miss));
`else
    chk("cnt_tied_zero", 128'({no_acc_o, no_hit_o, no_vc_hit_o, no_miss_o}), '0);
`endif
  endtask

  // One CPU access; called #1 after a rising edge, returns likewise
  task automatic do_req(input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic vch, input logic vcd, input logic [127:0] vcdata,
                        input int delay);
    int           idx, w, lat, exp_lat, exp_we, exp_mem;
    int           p0, e0, m0, w0, b0;
    logic [19:0]  tg;
    bit           hit, exp_ev, got;
    logic [31:0]  ev_addr, exp_rdata;
    logic         ev_dirty;
    logic [127:0] ev_data;
    idx = int'(addr[11:4]);
    w   = int'(addr[3:2]);
    tg  = addr[31:12];
    hit = ref_valid[idx] && (ref_tag[idx] == tg);
    exp_ev   = !hit && ref_valid[idx];
    ev_addr  = {ref_tag[idx], addr[11:4], 4'h0};
    ev_dirty = ref_dirty[idx];
    ev_data  = ref_data[idx];
    if (!hit) begin
      ref_data[idx]  = vch ? vcdata : mem_line({addr[31:4], 4'h0});
      ref_dirty[idx] = vch ? vcd : 1'b0;
      ref_valid[idx] = 1'b1;
      ref_tag[idx]   = tg;
    end
    exp_rdata = ref_data[idx][w*32 +: 32];
    if (rw) begin
      ref_data[idx][w*32 +: 32] = wdata;
      ref_dirty[idx] = 1'b1;
    end
    exp_lat = hit ? 2 : (vch ? 6 : 7 + delay);
    exp_we  = hit ? int'(rw) : 1 + int'(rw);
    exp_mem = (!hit && !vch) ? delay + 1 : 0;
    m_acc++;
    if (hit) m_hit++;
    else if (vch) m_vc++;
    else m_miss++;

    p0 = n_probe; e0 = n_evict; m0 = n_mem; w0 = n_we; b0 = n_both;
    vc_hit_i        = vch;
    vc_dirty_i      = vcd;
    vc_data_i       = vcdata;
    mem_delay       = delay;
    cpu_req_valid_i = 1'b1;
    cpu_req_rw_i    = rw;
    cpu_req_addr_i  = addr;
    cpu_req_data_i  = wdata;
    lat = 0;
    got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(posedge clk_i);
      #1;
      lat++;
      if (cpu_res_ready_o) got = 1'b1;
    end
    chk("resp_seen", 128'(got), 128'(1));
    chk("latency", 128'(lat), 128'(exp_lat));
    if (!rw) chk("load_data", 128'(cpu_res_data_o), 128'(exp_rdata));
    cpu_req_valid_i = 1'b0;
    @(posedge clk_i);
    #1;
    vc_hit_i = 1'b0;
    chk("probe_count", 128'(n_probe - p0), 128'(!hit));
    if (!hit) chk("probe_addr", 128'(last_probe_addr), 128'({addr[31:4], 4'h0}));
    chk("evict_count", 128'(n_evict - e0), 128'(exp_ev));
    if (exp_ev) begin
      chk("evict_addr", 128'(last_ev_addr), 128'(ev_addr));
      chk("evict_dirty", 128'(last_ev_dirty), 128'(ev_dirty));
      chk("evict_data", last_ev_data, ev_data);
    end
    chk("evict_probe_overlap", 128'(n_both - b0), '0);
    chk("mem_cycles", 128'(n_mem - m0), 128'(exp_mem));
    if (exp_mem != 0) chk("mem_addr", 128'(last_mem_addr), 128'({addr[31:4], 4'h0}));
    chk("l1_we_count", 128'(n_we - w0), 128'(exp_we));
    chk("l1_tag", 128'(tag_mem[idx]), 128'({1'b1, ref_dirty[idx], ref_tag[idx]}));
    chk("l1_data", data_mem[idx], ref_data[idx]);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation bound reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] vd;
    logic [31:0]  a;
    bit           got;
    for (int i = 0; i < 256; i++) begin
      ref_valid[i] = 1'b0;
      ref_dirty[i] = 1'b0;
      ref_tag[i]   = '0;
      ref_data[i]  = '0;
    end

    // Reset state
    @(posedge clk_i);
    #1;
    env_init = 1'b0;
    chk_outputs_zero();
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    // Bring line 0x00001230 into L1 through a VC hit, then hit on it
    vd = 128'h0BADF00D_CAFE0002_11112222_DEADBEEF;
    do_req(1'b0, 32'h00001230, '0, 1'b1, 1'b0, vd, 0);
    do_req(1'b0, 32'h00001230, '0, 1'b0, 1'b0, '0, 0);
    // Store hit: word 1, line becomes dirty
    do_req(1'b1, 32'h00001234, 32'h12345678, 1'b0, 1'b0, '0, 0);
    // VC hit swap displacing the dirty tag-1 line
    do_req(1'b0, 32'h00002230, '0, 1'b1, 1'b0, 128'h44444444_33333333_22222222_11111111, 0);
    // VC miss into an invalid line, memory ready after 3 cycles
    do_req(1'b0, 32'h00005400, '0, 1'b0, 1'b0, '0, 3);

    // Reset during MEM_REQ
    vc_hit_i        = 1'b0;
    mem_delay       = 50;
    cpu_req_valid_i = 1'b1;
    cpu_req_rw_i    = 1'b0;
    cpu_req_addr_i  = 32'h00009400;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(posedge clk_i);
      #1;
      if (mem_req_valid_o) got = 1'b1;
    end
    chk("mem_req_reached", 128'(got), 128'(1));
    rst_ni = 1'b0;
    #1;
    chk_outputs_zero();
    cpu_req_valid_i = 1'b0;
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    m_acc = 0; m_hit = 0; m_vc = 0; m_miss = 0;
    @(posedge clk_i);
    #1;
    chk("abandon_tag", 128'(tag_mem[8'h40]), 128'({1'b1, ref_dirty[8'h40], ref_tag[8'h40]}));

    // Three hits, one VC hit, one memory miss
    do_req(1'b0, 32'h00002230, '0, 1'b0, 1'b0, '0, 0);
    do_req(1'b0, 32'h00005408, '0, 1'b0, 1'b0, '0, 0);
    do_req(1'b1, 32'h00002238, 32'hA5A5C3C3, 1'b0, 1'b0, '0, 0);
    do_req(1'b0, 32'h00003230, '0, 1'b1, 1'b1, 128'h0F0F0F0F_F0F0F0F0_76543210_89ABCDEF, 0);
    do_req(1'b0, 32'h00007800, '0, 1'b0, 1'b0, '0, 0);
`ifdef L1VC_PERF_CNT_EN
    chk("plan_acc", 128'(no_acc_o), 128'(5));
    chk("plan_hit", 128'(no_hit_o), 128'(3));
    chk("plan_vc_hit", 128'(no_vc_hit_o), 128'(1));
    chk("plan_miss", 128'(no_miss_o), 128'(1));
`endif
    chk_counters();

    // Random traffic over a few sets and tags
    for (int n = 0; n < 40; n++) begin
      a = {12'h000, 4'($urandom_range(1, 4)), 4'hA, 2'b00, 2'($urandom_range(0, 3)),
           2'($urandom_range(0, 3)), 2'b00};
      vd = {$urandom, $urandom, $urandom, $urandom};
      do_req(1'($urandom_range(0, 1)), a, $urandom, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), vd, int'($urandom_range(0, 3)));
    end
    chk_counters();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
